// File: rtl/cla_add_sequencer.sv
// Sequences one WIDTH-bit add/subtract through a single SLICE-bit two-level carry-lookahead
// slice, one slice per cycle, with valid/ready handshakes on the operand and result sides.
module cla_add_sequencer #(
   parameter int WIDTH = 64,
   parameter int SLICE = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_sub,
   input  logic             in_cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_ovf,
   output logic             out_zero,
   output logic             busy
);

   localparam int NSLICE = WIDTH / SLICE;
   localparam int NGRP   = SLICE / 4;
   localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       r_state;
   logic [KW-1:0]    r_k;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_carry;
   logic [WIDTH-1:0] r_sum;
   logic             r_cout;
   logic             r_ovf;
   logic             r_zero;

   logic [SLICE-1:0] w_sa;
   logic [SLICE-1:0] w_sb;
   logic [SLICE-1:0] w_p;
   logic [SLICE-1:0] w_g;
   logic [SLICE-1:0] w_c;
   logic [NGRP-1:0]  w_gp;
   logic [NGRP-1:0]  w_gg;
   logic [NGRP:0]    w_cg;
   logic [SLICE-1:0] w_ssum;
   logic             w_scout;
   logic             w_cmsb;
   logic             w_last;
   logic [WIDTH-1:0] w_next_sum;

   assign w_sa   = r_a[int'(r_k) * SLICE +: SLICE];
   assign w_sb   = r_b[int'(r_k) * SLICE +: SLICE];
   assign w_last = (r_k == KW'(NSLICE - 1));

   // Group P/G first, then the second level gives each group's carry-in, then bit carries
   // inside each group, all in fully expanded sum-of-products form rather than a ripple.
   always_comb begin
      logic term;
      logic acc;
      w_p  = w_sa ^ w_sb;
      w_g  = w_sa & w_sb;
      w_gp = '0;
      w_gg = '0;
      w_cg = '0;
      w_c  = '0;
      for (int j = 0; j < NGRP; j++) begin
         w_gp[j] = &w_p[4*j +: 4];
         acc = 1'b0;
         for (int i = 0; i < 4; i++) begin
            term = w_g[4*j+i];
            for (int n = i + 1; n < 4; n++) term = term & w_p[4*j+n];
            acc = acc | term;
         end
         w_gg[j] = acc;
      end
      w_cg[0] = r_carry;
      for (int j = 0; j < NGRP; j++) begin
         acc = r_carry;
         for (int n = 0; n <= j; n++) acc = acc & w_gp[n];
         for (int m = 0; m <= j; m++) begin
            term = w_gg[m];
            for (int n = m + 1; n <= j; n++) term = term & w_gp[n];
            acc = acc | term;
         end
         w_cg[j+1] = acc;
      end
      for (int j = 0; j < NGRP; j++) begin
         for (int i = 0; i < 4; i++) begin
            acc = w_cg[j];
            for (int n = 0; n < i; n++) acc = acc & w_p[4*j+n];
            for (int m = 0; m < i; m++) begin
               term = w_g[4*j+m];
               for (int n = m + 1; n < i; n++) term = term & w_p[4*j+n];
               acc = acc | term;
            end
            w_c[4*j+i] = acc;
         end
      end
   end

   assign w_ssum  = w_p ^ w_c;
   assign w_scout = w_cg[NGRP];
   assign w_cmsb  = w_c[SLICE-1];

   always_comb begin
      w_next_sum = r_sum;
      w_next_sum[int'(r_k) * SLICE +: SLICE] = w_ssum;
   end

   // Flags are captured on the final slice edge so they stay frozen through DONE.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_k     <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_carry <= 1'b0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
         r_zero  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_a     <= in_a;
                  r_b     <= in_sub ? ~in_b : in_b;
                  r_carry <= in_sub | in_cin;
                  r_k     <= '0;
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               r_sum   <= w_next_sum;
               r_carry <= w_scout;
               r_k     <= w_last ? '0 : r_k + KW'(1);
               if (w_last) begin
                  r_cout  <= w_scout;
                  r_ovf   <= w_cmsb ^ w_scout;
                  r_zero  <= (w_next_sum == '0);
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               if (out_ready) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign in_ready  = (r_state == S_IDLE);
   assign out_valid = (r_state == S_DONE);
   assign busy      = (r_state != S_IDLE);
   assign out_sum   = r_sum;
   assign out_cout  = r_cout;
   assign out_ovf   = r_ovf;
   assign out_zero  = r_zero;

endmodule

// File: tb/tb_cla_add_sequencer.sv
// Self-checking bench for cla_add_sequencer: directed vector table, randomized ops against an
// arithmetic reference model, plus backpressure and mid-operation reset sequences.
module tb_cla_add_sequencer;

   localparam int NSLICE = 4;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_a;
   logic [63:0] in_b;
   logic        in_sub;
   logic        in_cin;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_sum;
   logic        out_cout;
   logic        out_ovf;
   logic        out_zero;
   logic        busy;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       name;
      logic [63:0] a;
      logic [63:0] b;
      logic        sub;
      logic        cin;
      logic [63:0] sum;
      logic        cout;
      logic        ovf;
      logic        zero;
   } vec_t;

   vec_t vecs[10];

   cla_add_sequencer #(.WIDTH(64), .SLICE(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_sub    (in_sub),
      .in_cin    (in_cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_cout  (out_cout),
      .out_ovf   (out_ovf),
      .out_zero  (out_zero),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: exact integer arithmetic with wide signed/unsigned sums.
   function automatic void refModel(input logic [63:0] a, input logic [63:0] b,
                                    input logic sub, input logic cin,
                                    output logic [63:0] s, output logic co,
                                    output logic ov, output logic z);
      logic [64:0]        full;
      logic signed [65:0] ea;
      logic signed [65:0] eb;
      logic signed [65:0] ex;
      ea = {{2{a[63]}}, a};
      eb = {{2{b[63]}}, b};
      if (sub) begin
         s  = a - b;
         co = (a >= b);
         ex = ea - eb;
      end else begin
         full = {1'b0, a} + {1'b0, b} + {64'd0, cin};
         s    = full[63:0];
         co   = full[64];
         ex   = ea + eb + {65'd0, cin};
      end
      ov = (ex[65:63] != 3'b000) && (ex[65:63] != 3'b111);
      z  = (s == 64'd0);
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic [63:0] a, input logic [63:0] b,
                                input logic sub, input logic cin);
      int n;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("accept_ready", 64'(in_ready), 64'd1);
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      in_sub   = sub;
      in_cin   = cin;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      in_a     = {$urandom, $urandom};
      in_b     = {$urandom, $urandom};
      in_sub   = 1'($urandom);
      in_cin   = 1'($urandom);
   endtask

   task automatic waitResult(output int lat);
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic checkOutput(input string name, input logic [63:0] s, input logic co,
                              input logic ov, input logic z, input int lat);
      chk({name, "_latency"}, 64'(lat), 64'(NSLICE));
      chk({name, "_valid"}, 64'(out_valid), 64'd1);
      chk({name, "_sum"}, out_sum, s);
      chk({name, "_cout"}, 64'(out_cout), 64'(co));
      chk({name, "_ovf"}, 64'(out_ovf), 64'(ov));
      chk({name, "_zero"}, 64'(out_zero), 64'(z));
      chk({name, "_inready"}, 64'(in_ready), 64'd0);
   endtask

   task automatic releaseResult();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic runVector(input string name, input logic [63:0] a, input logic [63:0] b,
                            input logic sub, input logic cin, input logic [63:0] s,
                            input logic co, input logic ov, input logic z);
      int lat;
      applyStimulus(a, b, sub, cin);
      waitResult(lat);
      checkOutput(name, s, co, ov, z, lat);
      releaseResult();
   endtask

   initial begin
      logic [63:0] es;
      logic        eco;
      logic        eov;
      logic        ez;
      logic [63:0] ra;
      logic [63:0] rb;
      logic        rsub;
      logic        rcin;
      logic        sawValid;
      int          lat;

      vecs[0] = '{"ones_plus1",   64'hFFFFFFFFFFFFFFFF, 64'd1, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0, 1'b1};
      vecs[1] = '{"maxpos_plus1", 64'h7FFFFFFFFFFFFFFF, 64'd1, 1'b0, 1'b0, 64'h8000000000000000, 1'b0, 1'b1, 1'b0};
      vecs[2] = '{"sub_5_7",      64'd5, 64'd7, 1'b1, 1'b1, 64'hFFFFFFFFFFFFFFFE, 1'b0, 1'b0, 1'b0};
      vecs[3] = '{"sub_7_5",      64'd7, 64'd5, 1'b1, 1'b0, 64'd2, 1'b1, 1'b0, 1'b0};
      vecs[4] = '{"cross32",      64'h00000000FFFFFFFF, 64'd1, 1'b0, 1'b0, 64'h0000000100000000, 1'b0, 1'b0, 1'b0};
      vecs[5] = '{"cross_cin",    64'h0000FFFF0000FFFF, 64'h0000000100000001, 1'b0, 1'b1, 64'h0001000000010001, 1'b0, 1'b0, 1'b0};
      vecs[6] = '{"sub_0_0",      64'd0, 64'd0, 1'b1, 1'b0, 64'd0, 1'b1, 1'b0, 1'b1};
      vecs[7] = '{"minneg_sub1",  64'h8000000000000000, 64'd1, 1'b1, 1'b0, 64'h7FFFFFFFFFFFFFFF, 1'b1, 1'b1, 1'b0};
      vecs[8] = '{"minneg_x2",    64'h8000000000000000, 64'h8000000000000000, 1'b0, 1'b0, 64'd0, 1'b1, 1'b1, 1'b1};
      vecs[9] = '{"cin_only",     64'd0, 64'd0, 1'b0, 1'b1, 64'd1, 1'b0, 1'b0, 1'b0};

      rst = 1'b1;
      in_valid = 1'b0;
      in_a = '0;
      in_b = '0;
      in_sub = 1'b0;
      in_cin = 1'b0;
      out_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_inready", 64'(in_ready), 64'd1);
      chk("reset_valid", 64'(out_valid), 64'd0);
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_sum", out_sum, 64'd0);
      chk("reset_flags", 64'({out_cout, out_ovf, out_zero}), 64'd0);
      rst = 1'b0;

      foreach (vecs[i])
         runVector(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin,
                   vecs[i].sum, vecs[i].cout, vecs[i].ovf, vecs[i].zero);

      for (int i = 0; i < 30; i++) begin
         ra   = {$urandom, $urandom};
         rb   = {$urandom, $urandom};
         rsub = 1'($urandom);
         rcin = 1'($urandom);
         case ($urandom_range(0, 3))
            0: rb = ~ra;
            1: rb = ra;
            2: ra = ra | 64'h0000FFFFFFFFFFFF;
            default: ;
         endcase
         refModel(ra, rb, rsub, rcin, es, eco, eov, ez);
         runVector("random", ra, rb, rsub, rcin, es, eco, eov, ez);
      end

      // Backpressure: result must stay frozen and no new op may slip in.
      refModel(64'h123456789ABCDEF0, 64'h0FEDCBA987654321, 1'b0, 1'b1, es, eco, eov, ez);
      applyStimulus(64'h123456789ABCDEF0, 64'h0FEDCBA987654321, 1'b0, 1'b1);
      waitResult(lat);
      checkOutput("bp", es, eco, eov, ez, lat);
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1;
         in_a     = 64'd100;
         in_b     = 64'd23;
         in_sub   = 1'b1;
         in_cin   = 1'b0;
         @(negedge clk);
         chk("bp_hold_valid", 64'(out_valid), 64'd1);
         chk("bp_hold_sum", out_sum, es);
         chk("bp_hold_flags", 64'({out_cout, out_ovf, out_zero}), 64'({eco, eov, ez}));
         chk("bp_hold_inready", 64'(in_ready), 64'd0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("bp_idle_valid", 64'(out_valid), 64'd0);
      chk("bp_idle_inready", 64'(in_ready), 64'd1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      chk("bp_next_busy", 64'(busy), 64'd1);
      waitResult(lat);
      checkOutput("bp_next", 64'd77, 1'b1, 1'b0, 1'b0, lat);
      releaseResult();

      // Reset while slice 2 is in flight abandons the operation.
      applyStimulus(64'hAAAAAAAAAAAAAAAA, 64'h5555555555555555, 1'b0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rstrun_inready", 64'(in_ready), 64'd1);
      chk("rstrun_valid", 64'(out_valid), 64'd0);
      chk("rstrun_busy", 64'(busy), 64'd0);
      chk("rstrun_sum", out_sum, 64'd0);
      sawValid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (out_valid) sawValid = 1'b1;
      end
      chk("rstrun_no_result", 64'(sawValid), 64'd0);
      runVector("after_rst", 64'd3, 64'd4, 1'b0, 1'b0, 64'd7, 1'b0, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cla_add_sequencer.md
# cla_add_sequencer

Multi-cycle controller that sequences one 64-bit add/subtract through a single 16-bit carry-lookahead slice. It makes four passes, one per slice, and registers the carry between them. It sits between an operand producer and a result consumer, each with its own valid/ready handshake, and lets the design trade the full 64-bit lookahead tree for a narrower, shared slice. Each slice is built internally from 4-bit generate/propagate lookahead groups plus one second-level group.

## Interface
- WIDTH, 64, total operand width; must be an integer multiple of SLICE
- SLICE, 16, slice width processed per cycle; must be a multiple of 4
- NSLICE, WIDTH/SLICE (derived, not overridable), number of slice passes
- clk  input  1  single clock; all state changes on rising edge
- rst  input  1  reset; one clock; reset is synchronous and active-high
- in_valid  input  1  operand request valid
- in_ready  output  1  block can accept operands
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B
- in_sub  input  1  1 = compute A - B, 0 = compute A + B + in_cin
- in_cin  input  1  carry-in for add; ignored when in_sub = 1
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_sum  output  WIDTH  result
- out_cout  output  1  carry out of MSB; for subtract, 1 = no borrow
- out_ovf  output  1  signed overflow
- out_zero  output  1  out_sum == 0
- busy  output  1  high in RUN or DONE

## Operation
- States are IDLE, RUN, DONE.
  - IDLE: in_ready = 1.
  - RUN: slice index k counts 0..NSLICE-1.
  - DONE: out_valid = 1.
- Accept happens on the edge where in_valid & in_ready.
  - On accept, capture A into a register.
  - Capture B as in_sub ? ~in_b : in_b.
  - Load the carry register with in_sub ? 1 : in_cin.
  - Set k = 0 and go to RUN.
- Operand inputs are not sampled outside the accept edge. Changes to them during RUN or DONE have no effect.
- Each RUN cycle does the following:
  - The slice computes sum[k*SLICE +: SLICE] from A slice k, B slice k and the carry register.
  - At the edge, write the sum bits into the result register.
  - Load the carry register with the slice carry-out.
  - Record the carry into the slice MSB: it is the carry into bit SLICE-1 for the slice being processed.
  - Increment k.
- At the edge that completes k = NSLICE-1, go to DONE.
  - out_cout = final carry.
  - out_ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
  - out_zero = (full result == 0).
- DONE holds out_sum and all flags stable while out_valid & !out_ready.
- On the edge with out_ready = 1 in DONE, go to IDLE.
- Each slice uses 4-bit groups computing p = a^b and g = a&b, with c[i+1] = g[i] | p[i]&c[i] expanded in lookahead form. The group P/G outputs feed a second-level lookahead across SLICE/4 groups. Arithmetic is modulo 2^WIDTH.
- No input bypass: in_ready is 0 in RUN and DONE, including the DONE cycle where out_ready = 1.

## Timing
- Reset (rst = 1 at an edge):
  - state = IDLE, k = 0.
  - in_ready = 1, out_valid = 0, busy = 0.
  - out_sum = 0, out_cout = 0, out_ovf = 0, out_zero = 0; the carry register is also cleared.
  - All of this takes effect after that edge regardless of the current state.
- Reset during RUN or DONE abandons the operation. No out_valid pulse is produced for it.
- Latency: accept at edge T. RUN occupies cycles T..T+NSLICE-1, and out_valid rises after edge T+NSLICE. With NSLICE = 4, out_valid is first high 4 cycles after accept.
- Throughput with out_ready tied high: one operation per NSLICE+2 cycles (NSLICE RUN + 1 DONE + 1 IDLE).
- All outputs are registered. There is no combinational path from in_* to out_* or from out_ready to in_ready.
- Simultaneous rst and handshake: rst wins; the operation is not accepted.

## Test plan
- A = 0xFFFFFFFFFFFFFFFF, B = 1, add, cin = 0 -> out_sum = 0, out_cout = 1, out_zero = 1, out_ovf = 0; out_valid first high 4 cycles after accept.
- A = 0x7FFFFFFFFFFFFFFF, B = 1, add -> out_sum = 0x8000000000000000, out_ovf = 1, out_cout = 0, out_zero = 0.
- Subtract checks:
  - 5 - 7 -> out_sum = 0xFFFFFFFFFFFFFFFE, out_cout = 0, out_ovf = 0.
  - 7 - 5 -> out_sum = 2, out_cout = 1.
- Cross-slice carry: A = 0x00000000FFFFFFFF, B = 1 -> 0x0000000100000000. Also A = 0x0000FFFF0000FFFF, B = 0x0000000100000001, cin = 1 -> 0x0001000000010001.
- Backpressure:
  - Hold out_ready = 0 for 10 cycles in DONE: out_sum and flags stay stable, in_ready = 0, and a new in_valid with different operands is not accepted.
  - Then raise out_ready: IDLE follows on the next edge, and the next op is accepted on the following edge.
- Assert rst for one cycle at RUN k = 2 -> after that edge IDLE, in_ready = 1, out_valid = 0, no result emitted. Then 3 + 4 -> out_sum = 7 with correct flags.
